// File: rtl/four_bit_counter_async_reset_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// four_bit_counter_async_reset_pkg : shared width/reset constants and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package four_bit_counter_async_reset_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_RST = 0;

  // All-ones value for a counter of width w (1..32), zero-extended to 32 bits.
  function automatic logic [31:0] all_ones(input int unsigned w);
    logic [32:0] v;
    v = (33'd1 << w) - 33'd1;
    return v[31:0];
  endfunction

endpackage : four_bit_counter_async_reset_pkg
`default_nettype wire

// File: rtl/four_bit_counter_async_reset_counter_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_core : WIDTH-bit async-reset count register, incrementer, tc compare
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_core
  import four_bit_counter_async_reset_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(CNT_RST);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             tc_d,  tc_q;

  // tc is computed from the next count and registered alongside it, so it
  // changes on the same edge as cnt and never glitches.
  always_comb begin
    cnt_d = cnt_q + ONE;
    tc_d  = (cnt_d == TERM_VAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;

endmodule : counter_core
`default_nettype wire

// File: rtl/four_bit_counter_async_reset.sv
`default_nettype none
// ----------------------------------------------------------------------------
// four_bit_counter_async_reset : free-running up-counter, async active-low reset
// Rev 1.0
// ----------------------------------------------------------------------------
module four_bit_counter_async_reset
  import four_bit_counter_async_reset_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .cnt     (cnt),
    .tc      (tc)
  );

endmodule : four_bit_counter_async_reset
`default_nettype wire

// File: tb/tb_four_bit_counter_async_reset.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_four_bit_counter_async_reset : directed scoreboard bench, WIDTH 4 and 6
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_four_bit_counter_async_reset;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] cnt4;
  logic       tc4;
  logic [5:0] cnt6;
  logic       tc6;

  int vectors = 0;
  int errors  = 0;
  int m4 = 0;
  int m6 = 0;
  int tc_seen = 0;
  int tc_want = 0;

  typedef struct {
    logic [3:0] c4;
    logic       t4;
    logic [5:0] c6;
    logic       t6;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  four_bit_counter_async_reset dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .cnt     (cnt4),
    .tc      (tc4)
  );

  four_bit_counter_async_reset #(.WIDTH(6)) dut6 (
    .clk     (clk),
    .reset_n (reset_n),
    .cnt     (cnt6),
    .tc      (tc6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".cnt4"}, 32'(cnt4), 32'd0);
    chk({tag, ".tc4"},  32'(tc4),  32'd0);
    chk({tag, ".cnt6"}, 32'(cnt6), 32'd0);
    chk({tag, ".tc6"},  32'(tc6),  32'd0);
  endtask

  task automatic push_exp();
    exp_t e;
    e.c4 = 4'(m4);
    e.t4 = (m4 == 15);
    e.c6 = 6'(m6);
    e.t6 = (m6 == 63);
    sb.push_back(e);
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    if (reset_n) begin
      m4 = (m4 + 1) % 16;
      m6 = (m6 + 1) % 64;
    end else begin
      m4 = 0;
      m6 = 0;
    end
    push_exp();
    @(negedge clk);
    if (tc4) tc_seen++;
    if (m4 == 15) tc_want++;
    e = sb.pop_front();
    chk({tag, ".cnt4"}, 32'(cnt4), 32'(e.c4));
    chk({tag, ".tc4"},  32'(tc4),  32'(e.t4));
    chk({tag, ".cnt6"}, 32'(cnt6), 32'(e.c6));
    chk({tag, ".tc6"},  32'(tc6),  32'(e.t6));
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    m4 = 0;
    m6 = 0;
    #1;
    chk_zero(tag);
  endtask

  initial begin
    // First reset, before any clock edge.
    #2;
    async_reset("por");

    // Hold reset 100 cycles, release on a falling edge.
    for (int i = 0; i < 100; i++) tick("hold");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick("wrap4");

    // Count to 7, then reset mid-period with clk low.
    for (int i = 0; i < 16 && m4 != 7; i++) tick("to7");
    chk("at7", 32'(cnt4), 32'd7);
    #2;
    async_reset("async7");
    for (int i = 0; i < 3; i++) tick("held");
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("restart");

    // Reset while at terminal count.
    for (int i = 0; i < 16 && m4 != 15; i++) tick("to15");
    chk("tc_at15", 32'(tc4), 32'd1);
    #3;
    async_reset("async15");
    @(negedge clk);
    reset_n = 1'b1;
    tick("after15");

    // Reset asserted exactly on a rising edge: reset wins.
    for (int i = 0; i < 4; i++) tick("pre_coin");
    @(posedge clk);
    reset_n = 1'b0;
    m4 = 0;
    m6 = 0;
    @(negedge clk);
    chk_zero("coincident");

    // Long run: ~1000 ns in reset, then ~4000 ns counting; both widths wrap.
    for (int i = 0; i < 99; i++) tick("long_rst");
    reset_n = 1'b1;
    tc_seen = 0;
    tc_want = 0;
    for (int i = 0; i < 400; i++) tick("long");
    chk("tc_pulses", 32'(tc_seen), 32'(tc_want));
    chk("tc_pulses_n", 32'(tc_seen), 32'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_four_bit_counter_async_reset
`default_nettype wire
